// File: rtl/instr_loader.sv
// Program loader: parses a length-prefixed 9-bit word stream, writes the payload to
// instruction RAM from address 0, verifies a trailing XOR checksum and gates core reset.
module instr_loader #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [8:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         mem_we,
  output logic [D-1:0] mem_addr,
  output logic [8:0]   mem_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         core_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t       state, next_state;
  logic [8:0]   len_hi_q;
  logic [8:0]   csum_q;
  logic [D-1:0] len_q;
  logic [D:0]   addr_q;
  logic         accept;
  logic [17:0]  len_full;
  logic         len_ok;
  logic         last_word;
  logic         next_busy;

  assign accept    = in_valid && in_ready;
  assign len_full  = {len_hi_q, in_data};
  // Any header bit at or above D means the program cannot fit in the RAM.
  assign len_ok    = (len_full >> D) == 18'd0;
  assign last_word = (addr_q + 1'b1) == {1'b0, len_q};
  assign next_busy = next_state inside {S_LEN_HI, S_LEN_LO, S_LOAD, S_CSUM};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: next_state gets a default before the case so no path can infer a latch.
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_HI;
      S_LEN_HI:              if (accept) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (!len_ok)              next_state = S_ERR;
          else if (len_full == '0)  next_state = S_CSUM;
          else                      next_state = S_LOAD;
        end
      end
      S_LOAD:                if (accept && last_word) next_state = S_CSUM;
      S_CSUM: begin
        if (accept) next_state = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default:               next_state = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the state being entered, so they change with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      len_hi_q  <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      csum_q    <= '0;
    end else begin
      in_ready  <= next_busy;
      busy      <= next_busy;
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERR);
      core_hold <= (next_state != S_DONE);
      mem_we    <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            addr_q <= '0;
            csum_q <= '0;
          end
        end
        S_LEN_HI: if (accept) len_hi_q <= in_data;
        S_LEN_LO: if (accept) len_q <= len_full[D-1:0];
        S_LOAD: begin
          if (accept) begin
            mem_we   <= 1'b1;
            mem_addr <= addr_q[D-1:0];
            mem_data <= in_data;
            csum_q   <= csum_q ^ in_data;
            addr_q   <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: nominal, bad checksum, backpressure, length bounds,
// reset mid-load and reload scenarios, each with hand-computed expectations.
module tb_instr_loader;

  localparam int D = 12;

  logic         clk;
  logic         reset;
  logic         start;
  logic [8:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         mem_we;
  logic [D-1:0] mem_addr;
  logic [8:0]   mem_data;
  logic         busy;
  logic         done;
  logic         error;
  logic         core_hold;

  int errors = 0;
  int checks = 0;

  instr_loader #(.D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .core_hold (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one word and hold it until accepted; ok=0 if the bound expires.
  task automatic send_word(input logic [8:0] w, output bit ok, output int cycles);
    bit acc;
    in_data  = w;
    in_valid = 1'b1;
    ok       = 1'b0;
    cycles   = 0;
    while (!ok && cycles < 20) begin
      acc = in_ready;
      step();
      cycles++;
      if (acc) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 9'h155;
    #12;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_data !== '0)    begin errors++; $display("FAIL reset_mem_data got=%h want=0", mem_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (error !== 1'b0)     begin errors++; $display("FAIL reset_error got=%b want=0", error); end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold got=%b want=1", core_hold); end
    step();
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_no_accept in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
  endtask

  // Full load of header 0x000,0x003, payload 0x07E,0x066,0x07A and the given checksum word.
  task automatic do_load(input logic [8:0] csum_w, input bit gaps, input string tag);
    logic [8:0] stream [6];
    int         gap_tab [6];
    logic [8:0] exp_csum;
    bit         good;
    bit         ok;
    int         cyc;
    stream  = '{9'h000, 9'h003, 9'h07E, 9'h066, 9'h07A, csum_w};
    gap_tab = '{2, 0, 1, 3, 1, 2};
    exp_csum = 9'h07E ^ 9'h066 ^ 9'h07A;
    good = (csum_w == exp_csum);

    pulse_start();
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL %s start_busy got=%b want=1", tag, busy); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL %s start_in_ready got=%b want=1", tag, in_ready); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL %s start_status got done=%b error=%b want 0/0", tag, done, error);
    end
    checks++; if (core_hold !== 1'b1) begin errors++; $display("FAIL %s start_core_hold got=%b want=1", tag, core_hold); end

    for (int i = 0; i < 6; i++) begin
      if (gaps) begin
        for (int g = 0; g < gap_tab[i]; g++) begin
          step();
          checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s gap%0d_%0d got we=%b ready=%b want 0/1", tag, i, g, mem_we, in_ready);
          end
        end
      end
      send_word(stream[i], ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL %s word%0d_accept timed out want accepted", tag, i); end
      if (!gaps) begin
        checks++; if (cyc != 1) begin errors++; $display("FAIL %s word%0d_cycles got=%0d want=1", tag, i, cyc); end
      end
      if (i >= 2 && i <= 4) begin
        checks++; if (mem_we !== 1'b1 || mem_addr !== D'(i - 2) || mem_data !== stream[i]) begin
          errors++;
          $display("FAIL %s write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   tag, i - 2, mem_we, mem_addr, mem_data, i - 2, stream[i]);
        end
      end else begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL %s no_write%0d got we=%b want=0", tag, i, mem_we); end
      end
    end

    checks++; if (done !== good || error !== !good || core_hold !== !good) begin
      errors++;
      $display("FAIL %s status got done=%b error=%b hold=%b want done=%b error=%b hold=%b",
               tag, done, error, core_hold, good, !good, !good);
    end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s end_idle got busy=%b ready=%b want 0/0", tag, busy, in_ready);
    end
    step();
    checks++; if (mem_we !== 1'b0 || done !== good || error !== !good) begin
      errors++; $display("FAIL %s sticky got we=%b done=%b error=%b want 0/%b/%b", tag, mem_we, done, error, good, !good);
    end
  endtask

  task automatic test_nominal();
    do_load(9'h062, 1'b0, "nominal");
  endtask

  task automatic test_bad_checksum();
    do_load(9'h063, 1'b0, "bad_csum");
  endtask

  task automatic test_backpressure();
    do_load(9'h062, 1'b1, "backpressure");
  endtask

  task automatic test_len_zero();
    bit ok;
    int cyc;
    // start and a valid word together: the word must not be taken as a header.
    in_data  = 9'h1FF;
    in_valid = 1'b1;
    pulse_start();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL len0_start got busy=%b done=%b want 1/0", busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      send_word(9'h000, ok, cyc);
      checks++; if (!ok || mem_we !== 1'b0) begin
        errors++; $display("FAIL len0_word%0d got ok=%b we=%b want 1/0", i, ok, mem_we);
      end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || core_hold !== 1'b0) begin
      errors++; $display("FAIL len0_status got done=%b error=%b hold=%b want 1/0/0", done, error, core_hold);
    end
  endtask

  task automatic test_len_overflow();
    bit ok;
    int cyc;
    pulse_start();
    send_word(9'h008, ok, cyc);
    checks++; if (!ok || error !== 1'b0) begin errors++; $display("FAIL ovf_hdr_hi got ok=%b error=%b want 1/0", ok, error); end
    send_word(9'h000, ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_hdr_lo timed out want accepted"); end
    checks++; if (error !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
      errors++; $display("FAIL ovf_status got error=%b done=%b hold=%b want 1/0/1", error, done, core_hold);
    end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL ovf_idle got ready=%b busy=%b we=%b want 0/0/0", in_ready, busy, mem_we);
    end
    in_valid = 1'b1;
    in_data  = 9'h0AA;
    step();
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_after got we=%b ready=%b want 0/0", mem_we, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [8:0] words [4];
    bit ok;
    int cyc;
    words = '{9'h000, 9'h003, 9'h07E, 9'h066};
    pulse_start();
    foreach (words[i]) begin
      send_word(words[i], ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL rst_mid word%0d timed out want accepted", i); end
    end
    checks++; if (mem_we !== 1'b1 || mem_addr !== D'(1)) begin
      errors++; $display("FAIL rst_mid_prewrite got we=%b addr=%0d want 1/1", mem_we, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
      errors++; $display("FAIL rst_mid_mem got we=%b addr=%0d data=%h want 0/0/0", mem_we, mem_addr, mem_data);
    end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ctl got ready=%b busy=%b done=%b error=%b hold=%b want 0/0/0/0/1",
               in_ready, busy, done, error, core_hold);
    end
    reset = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_needs_start got busy=%b ready=%b want 0/0", busy, in_ready);
    end
    do_load(9'h062, 1'b0, "reload_after_reset");
  endtask

  task automatic test_reload();
    bit ok;
    int cyc;
    pulse_start();
    checks++; if (done !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reload_start got done=%b hold=%b busy=%b want 0/1/1", done, core_hold, busy);
    end
    send_word(9'h000, ok, cyc);
    send_word(9'h003, ok, cyc);
    send_word(9'h07E, ok, cyc);
    checks++; if (!ok || mem_addr !== D'(0) || mem_we !== 1'b1) begin
      errors++; $display("FAIL reload_w0 got ok=%b we=%b addr=%0d want 1/1/0", ok, mem_we, mem_addr);
    end
    start = 1'b1;
    send_word(9'h066, ok, cyc);
    start = 1'b0;
    checks++; if (!ok || mem_we !== 1'b1 || mem_addr !== D'(1) || mem_data !== 9'h066 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_start_ignored got we=%b addr=%0d data=%h busy=%b want 1/1/066/1",
               mem_we, mem_addr, mem_data, busy);
    end
    send_word(9'h07A, ok, cyc);
    checks++; if (!ok || mem_addr !== D'(2) || mem_data !== 9'h07A) begin
      errors++; $display("FAIL reload_w2 got addr=%0d data=%h want 2/07a", mem_addr, mem_data);
    end
    send_word(9'h062, ok, cyc);
    checks++; if (!ok || done !== 1'b1 || core_hold !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reload_done got done=%b hold=%b error=%b want 1/0/0", done, core_hold, error);
    end
  endtask

  initial begin
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reset    = 1'b1;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_backpressure();
    test_len_zero();
    test_len_overflow();
    test_reset_mid_load();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the instruction memory over a 9-bit valid/ready word stream. It replaces file-based program loading. It parses a length header, writes each payload word to consecutive instruction addresses starting at 0, and verifies a trailing XOR checksum. It holds the core in reset until a load completes successfully. It sits between the host or testbench word source and the write port of the instruction RAM that the core's `prog_ctr` reads.

## Interface
- `D`, 12, instruction address width (1..17); memory depth 2**D
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a load when not busy
- `in_data`  in  9  stream word
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts `in_data` this cycle
- `mem_we`  out  1  instruction RAM write enable
- `mem_addr`  out  D  instruction RAM write address
- `mem_data`  out  9  instruction RAM write data (machine code)
- `busy`  out  1  load in progress
- `done`  out  1  last load succeeded; sticky until next `start` or reset
- `error`  out  1  last load failed; sticky until next `start` or reset
- `core_hold`  out  1  holds the processor in reset while high

## Operation
- Transfer happens when `in_valid && in_ready` are both high on a rising edge. The source must hold `in_data` stable while `in_valid` is high and `in_ready` is low.
- FSM states: IDLE, LEN_HI, LEN_LO, LOAD, CSUM, DONE, ERR.
- IDLE, DONE or ERR with `start` high goes to LEN_HI. Entering LEN_HI does the following:
  - clears the address counter and checksum
  - clears `done` and `error`
  - drives `core_hold` high
- `start` is ignored in LEN_HI, LEN_LO, LOAD and CSUM.
- LEN_HI: accepts word h. LEN_LO: accepts word l.
- len = {h,l} (18 bits). If any bit of len at or above position D is set, go to ERR. Otherwise:
  - len = 0 goes to CSUM.
  - len > 0 goes to LOAD.
- LOAD: each accepted word w does the following:
  - writes w to address a, where a starts at 0
  - sets checksum ^= w
  - increments a
- After the len-th word, LOAD goes to CSUM.
- CSUM: accepts one word. If it equals the running XOR, go to DONE. Otherwise go to ERR.
- Outputs by state:
  - DONE: `done`=1, `core_hold`=0.
  - ERR: `error`=1, `core_hold`=1. Words already written stay in RAM.
- `in_ready` is 1 exactly in LEN_HI, LEN_LO, LOAD and CSUM. It is a registered function of state, so it does not depend on `in_valid` combinationally.
- `busy` is 1 in LEN_HI, LEN_LO, LOAD and CSUM.
- Address arithmetic: a is D+1 bits internally. len ≤ 2**D−1, so `mem_addr` never wraps.
- Words presented in IDLE, DONE or ERR are not accepted (`in_ready`=0).

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_data` 0, `busy` 0, `done` 0, `error` 0, `core_hold` 1.
- All outputs are registered.
- `start` sampled at edge k: `busy` and `in_ready` go high after edge k.
- Write latency is 1 cycle. A payload word accepted at edge k produces `mem_we`=1 with `mem_addr`/`mem_data` valid during the cycle after edge k, for exactly one cycle.
- Back-to-back acceptance yields one write per cycle at throughput 1.
- `in_ready` drops in the cycle after the final CSUM acceptance, and in the cycle after a bad length.
- Status timing relative to the accepting edge:
  - `done` and `core_hold`=0 appear after the checksum-accept edge.
  - `error` appears after the failing-word edge.
- Reset asserted mid-load has the following effect:
  - immediate return to reset values, asynchronously
  - any in-flight `mem_we` is dropped
  - a new `start` is required afterward
- Simultaneous `start` and `in_valid` in IDLE: `start` is taken and no word is accepted that cycle.

## Test plan
- Nominal load with D=12: start, then 0x000, 0x003, 0x07E, 0x066, 0x07A, checksum 0x062 → writes (0,0x07E), (1,0x066), (2,0x07A) on consecutive cycles; `done`=1 and `core_hold`=0 one cycle after the checksum word.
- Bad checksum: same stream ending 0x063 → three writes occur, then `error`=1, `core_hold`=1, `done`=0.
- Backpressure: `in_valid` toggled randomly during the nominal load → identical writes; no word lost or duplicated; `mem_we` only in the cycle after each accepted payload word.
- Length bounds:
  - len=0: header 0x000, 0x000, checksum 0x000 → no `mem_we`, `done`=1.
  - Header 0x008, 0x000 (len=4096 with D=12) → `error`=1 after the second header word; no writes.
- Reset mid-load: assert `reset` after the 2nd payload word → all outputs take reset values immediately. A later start plus a full stream reloads from address 0 and reaches `done`.
- Reload: after `done`, pulse `start` → `done` clears and `core_hold`=1 next cycle. `start` pulsed during LOAD is ignored and the load continues.
